uart_key_matrix: RTL and testbench

//  Converts ASCII bytes from the serial keyboard receiver (uart_rx data/valid)

---
 rtl/uart_key_matrix_if.sv | 22 ++
 rtl/uart_key_matrix.sv | 147 ++++++++++++++
 tb/tb_uart_key_matrix.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_key_matrix_if.sv
// Bundle between the serial keyboard receiver, the CPU key-read mux and uart_key_matrix.
// rx_valid is a one-cycle strobe with no ready: the producer never stalls, so a full FIFO drops the byte and raises overflow.
interface uart_key_matrix_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [5:0]  key_addr;
    logic        key_pressed;
    logic [63:0] key_matrix;
    logic        busy;
    logic        overflow;
    logic [1:0]  state_dbg;

    modport master (
        output rx_data, rx_valid, key_addr,
        input  key_pressed, key_matrix, busy, overflow, state_dbg
    );

    modport slave (
        input  rx_data, rx_valid, key_addr,
        output key_pressed, key_matrix, busy, overflow, state_dbg
    );
endinterface

// File: rtl/uart_key_matrix.sv
// ASCII bytes from uart_rx are decoded, queued, and replayed as timed presses on the
// 64-key Galaksija matrix, with a release gap after each key so repeats register.
module uart_key_matrix #(
    parameter int F_CLK   = 25000000,
    parameter int HOLD_MS = 40,
    parameter int GAP_MS  = 20,
    parameter int FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_key_matrix_if.slave  bus
);

    localparam int          DEPTH     = 2 ** FIFO_AW;
    localparam logic [31:0] HOLD_CYC  = 32'(F_CLK / 1000 * HOLD_MS);
    localparam logic [31:0] GAP_CYC   = 32'(F_CLK / 1000 * GAP_MS);
    localparam logic [63:0] SHIFT_BIT = 64'd1 << 53;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [31:0]      cnt;
    logic [63:0]      key_matrix_q;
    logic             overflow_q;
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [6:0]       fifo_mem [DEPTH];

    logic       dec_mapped;
    logic       dec_shift;
    logic [5:0] dec_code;
    logic [6:0] head;
    logic       empty;
    logic       full;
    logic       pop;
    logic       push;

    // Entry layout is {shift, code}; shifted symbols share codes with digits and punctuation.
    always_comb begin
        dec_mapped = 1'b1;
        dec_shift  = 1'b0;
        dec_code   = 6'd0;
        case (bus.rx_data) inside
            [8'h41:8'h5A], [8'h61:8'h7A]: dec_code = {1'b0, bus.rx_data[4:0]};
            [8'h30:8'h39]: dec_code = {2'b10, bus.rx_data[3:0]};
            8'h0A, 8'h0D:  dec_code = 6'd48;
            8'h08, 8'h7F:  dec_code = 6'd29;
            8'h1B:         dec_code = 6'd49;
            8'h20:         dec_code = 6'd31;
            8'h3B:         dec_code = 6'd42;
            8'h3A:         dec_code = 6'd43;
            8'h2C:         dec_code = 6'd44;
            8'h3D:         dec_code = 6'd45;
            8'h2E:         dec_code = 6'd46;
            8'h2F:         dec_code = 6'd47;
            8'h5F: begin dec_shift = 1'b1; dec_code = 6'd32; end
            8'h21: begin dec_shift = 1'b1; dec_code = 6'd33; end
            8'h22: begin dec_shift = 1'b1; dec_code = 6'd34; end
            8'h23: begin dec_shift = 1'b1; dec_code = 6'd35; end
            8'h24: begin dec_shift = 1'b1; dec_code = 6'd36; end
            8'h25: begin dec_shift = 1'b1; dec_code = 6'd37; end
            8'h26: begin dec_shift = 1'b1; dec_code = 6'd38; end
            8'h5C: begin dec_shift = 1'b1; dec_code = 6'd39; end
            8'h28: begin dec_shift = 1'b1; dec_code = 6'd40; end
            8'h29: begin dec_shift = 1'b1; dec_code = 6'd41; end
            8'h2B: begin dec_shift = 1'b1; dec_code = 6'd42; end
            8'h2A: begin dec_shift = 1'b1; dec_code = 6'd43; end
            8'h3C: begin dec_shift = 1'b1; dec_code = 6'd44; end
            8'h2D: begin dec_shift = 1'b1; dec_code = 6'd45; end
            8'h3E: begin dec_shift = 1'b1; dec_code = 6'd46; end
            8'h3F: begin dec_shift = 1'b1; dec_code = 6'd47; end
            default: dec_mapped = 1'b0;
        endcase
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop   = (state == IDLE) && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push  = bus.rx_valid && dec_mapped && (!full || pop);
    assign head  = fifo_mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {dec_shift, dec_code};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= 32'd0;
            key_matrix_q <= 64'd0;
            overflow_q   <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (bus.rx_valid && dec_mapped && full && !pop) begin
                overflow_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!empty) begin
                        rd_ptr       <= rd_ptr + 1'b1;
                        key_matrix_q <= (64'd1 << head[5:0]) | (head[6] ? SHIFT_BIT : 64'd0);
                        cnt          <= HOLD_CYC - 32'd1;
                        state        <= PRESS;
                    end else begin
                        key_matrix_q <= 64'd0;
                    end
                end
                PRESS: begin
                    if (cnt == 32'd0) begin
                        key_matrix_q <= 64'd0;
                        cnt          <= GAP_CYC - 32'd1;
                        state        <= GAP;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                GAP: begin
                    if (cnt == 32'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.key_matrix  = key_matrix_q;
    assign bus.key_pressed = key_matrix_q[bus.key_addr];
    assign bus.busy        = !empty || (state != IDLE);
    assign bus.overflow    = overflow_q;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_uart_key_matrix.sv
// Directed bench for uart_key_matrix: per-cycle key_matrix waveforms compared against
// hand-built expected queues, plus overflow, unmapped bytes, reset abort and key_addr sweep.
`timescale 1ns/1ps
module tb_uart_key_matrix;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  logic [7:0]  tx_q[$];
  logic [63:0] exp_q[$];

  uart_key_matrix_if kif ();

  uart_key_matrix #(
    .F_CLK   (1000),
    .HOLD_MS (4),
    .GAP_MS  (2),
    .FIFO_AW (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (kif.slave)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] bit_of(input int idx);
    logic [63:0] one;
    one = 64'd1;
    return one << idx;
  endfunction

  // Each key: held 4 cycles, then 2 gap cycles + 1 idle cycle with nothing pressed.
  task automatic add_key(input logic [63:0] k);
    repeat (4) exp_q.push_back(k);
    repeat (3) exp_q.push_back(64'd0);
  endtask

  // driver + checker in parallel; starts and ends on a negedge
  task automatic run_case(input string tag);
    int n;
    n = exp_q.size();
    fork
      begin
        while (tx_q.size() > 0) begin
          kif.rx_data  = tx_q.pop_front();
          kif.rx_valid = 1'b1;
          @(negedge clk);
        end
        kif.rx_valid = 1'b0;
      end
      begin
        for (int c = 0; c < n; c++) begin
          @(negedge clk);
          check($sformatf("%s_km[%0d]", tag, c), kif.key_matrix, exp_q.pop_front());
        end
      end
    join
    check($sformatf("%s_busy_end", tag), 64'(kif.busy), 64'd0);
  endtask

  initial begin
    logic [63:0] seen;
    checks       = 0;
    errors       = 0;
    reset_n      = 1'b0;
    kif.rx_data  = 8'h00;
    kif.rx_valid = 1'b0;
    kif.key_addr = 6'd0;
    repeat (3) @(negedge clk);
    check("rst_km", kif.key_matrix, 64'd0);
    check("rst_busy", 64'(kif.busy), 64'd0);
    check("rst_ovf", 64'(kif.overflow), 64'd0);
    check("rst_state", 64'(kif.state_dbg), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 'A' -> code 1
    tx_q = {8'h41};
    exp_q.push_back(64'd0);
    add_key(64'h2);
    run_case("A");

    // '!' -> 33 with SHIFT
    tx_q = {8'h21};
    exp_q.push_back(64'd0);
    add_key(bit_of(33) | bit_of(53));
    run_case("bang");

    // ';' -> 42 unshifted
    tx_q = {8'h3B};
    exp_q.push_back(64'd0);
    add_key(bit_of(42));
    run_case("semi");

    // "AA" back to back
    tx_q = {8'h41, 8'h41};
    exp_q.push_back(64'd0);
    add_key(64'h2);
    add_key(64'h2);
    run_case("AA");

    // lowercase, digit and CR mix
    tx_q = {8'h7A, 8'h30, 8'h0D};
    exp_q.push_back(64'd0);
    add_key(bit_of(26));
    add_key(bit_of(32));
    add_key(bit_of(48));
    run_case("mix");

    // unmapped bytes: nothing happens
    tx_q = {8'h80, 8'h40};
    repeat (6) exp_q.push_back(64'd0);
    run_case("unmapped");
    check("unmapped_ovf", 64'(kif.overflow), 64'd0);

    // 6 bytes into depth-4 FIFO: 5 pressed in order, 6th dropped
    tx_q = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    exp_q.push_back(64'd0);
    for (int i = 1; i <= 5; i++) add_key(bit_of(i));
    run_case("ovf");
    check("ovf_flag", 64'(kif.overflow), 64'd1);
    repeat (5) @(negedge clk);
    check("ovf_sticky", 64'(kif.overflow), 64'd1);

    // key_addr sweep during the press of '5' (code 37)
    kif.rx_data  = 8'h35;
    kif.rx_valid = 1'b1;
    @(negedge clk);
    kif.rx_valid = 1'b0;
    @(negedge clk);
    check("sweep_km", kif.key_matrix, bit_of(37));
    for (int a = 0; a < 64; a++) begin
      kif.key_addr = 6'(a);
      #0.05;
      check($sformatf("sweep_kp[%0d]", a), 64'(kif.key_pressed), (a == 37) ? 64'd1 : 64'd0);
    end
    kif.key_addr = 6'd0;
    @(negedge clk);
    repeat (8) @(negedge clk);
    check("sweep_busy_end", 64'(kif.busy), 64'd0);

    // reset during the press of 'Z' with 'A','B' queued
    kif.rx_data  = 8'h5A;
    kif.rx_valid = 1'b1;
    @(negedge clk);
    kif.rx_data  = 8'h41;
    @(negedge clk);
    check("rstmid_pressZ", kif.key_matrix, bit_of(26));
    kif.rx_data  = 8'h42;
    @(negedge clk);
    kif.rx_valid = 1'b0;
    reset_n      = 1'b0;
    @(negedge clk);
    check("rstmid_km", kif.key_matrix, 64'd0);
    check("rstmid_busy", 64'(kif.busy), 64'd0);
    check("rstmid_ovf", 64'(kif.overflow), 64'd0);
    reset_n = 1'b1;
    seen = 64'd0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      seen = seen | kif.key_matrix | 64'(kif.busy);
    end
    check("rstmid_after", seen, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
